muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: base ALU operation decode plus a multi-cycle M-extension sequencer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ALUOp/Funct7/Funct3 : instruction decode fields
//   start, op_a, op_b   : request strobe and rs1/rs2 operands
//   flush               : abort any in-flight M operation
//   Operation           : combinational ALU select (1111 for M-ops)
//   stall, busy, done   : pipeline hold, MUL/DIV in progress, one-cycle result-valid pulse
//   result              : M-extension result, held until the next done
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic [3:0]      Operation,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e                state_q, state_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;     // MUL: {partial, multiplier}; DIV: {rem, quotient}
  logic [XLEN-1:0]       b_q, b_d;         // multiplicand or divisor magnitude
  logic [XLEN-1:0]       result_q, result_d;
  logic [2:0]            f3_q, f3_d;
  logic                  neg_q, neg_d;     // negate final value
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Base decode
  logic is_mop;
  assign is_mop = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);

  always_comb begin
    Operation = 4'b0000;
    unique case (ALUOp)
      2'b00: if (Funct3 == 3'b010) Operation = 4'b0010;
      2'b01: if (Funct3 == 3'b000) Operation = 4'b1000;
      2'b10: begin
        if (is_mop) begin
          Operation = 4'b1111;
        end else begin
          unique case (Funct3)
            3'b000: begin
              if (Funct7 == 7'b0000000)      Operation = 4'b0010;
              else if (Funct7 == 7'b0100000) Operation = 4'b0011;
            end
            3'b001: Operation = 4'b0110;
            3'b010: Operation = 4'b1100;
            3'b100: Operation = 4'b0100;
            3'b101: begin
              if (Funct7 == 7'b0000000)      Operation = 4'b0101;
              else if (Funct7 == 7'b0100000) Operation = 4'b0111;
            end
            3'b110: Operation = 4'b0001;
            default: Operation = 4'b0000;
          endcase
        end
      end
      default: Operation = 4'b0000;
    endcase
  end

  // Operand conditioning at accept: signed operands are captured as magnitudes plus a sign.
  logic            is_mul, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, accept;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_mul   = ~Funct3[2];
  assign a_signed = is_mul ? (Funct3 == 3'b001 || Funct3 == 3'b010) : ~Funct3[0];
  assign b_signed = is_mul ? (Funct3 == 3'b001) : ~Funct3[0];
  assign a_neg    = a_signed & op_a[XLEN-1];
  assign b_neg    = b_signed & op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign div_ovf  = ~Funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign accept   = start && is_mop && (state_q == StIdle) && !flush;

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, mul_fix;
  logic [XLEN-1:0]   div_sel, div_fix, mul_res;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  // Borrow out means the trial subtraction failed: restore by keeping the shifted remainder.
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign mul_fix   = neg_q ? -mul_next : mul_next;
  assign mul_res   = (f3_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
  assign div_sel   = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
  assign div_fix   = neg_q ? -div_sel : div_sel;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          f3_d  = Funct3;
          cnt_d = '0;
          // Remainder takes the dividend's sign; everything else the xor of both.
          neg_d = (is_mul || !Funct3[1]) ? (a_neg ^ b_neg) : a_neg;
          if (is_mul) begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            b_d     = a_mag;
            state_d = StMul;
          end else if (div_zero) begin
            result_d = Funct3[1] ? op_a : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = Funct3[1] ? '0 : op_a;
            state_d  = StDone;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            b_d     = b_mag;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          result_d = mul_res;
          state_d  = StDone;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          result_d = div_fix;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == StMul) || (state_q == StDiv);
  assign done   = (state_q == StDone);
  // Gated by rst_n so a pending start cannot stall the pipeline while in reset.
  assign stall  = rst_n && (accept || busy);
  assign result = result_q;

endmodule
